// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// One access in flight; request-to-ack latency is MEM_LAT+2 cycles.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state, state_next;
    logic          owner_dm;
    logic          owner_we;
    logic [2:0]    lat_cnt;
    logic [SW-1:0] starve_cnt;
    logic          grant_dm, grant_if, capture;
    logic          if_cand, dm_cand, fetch_first;

    assign if_cand     = if_req & ~if_ack;
    assign dm_cand     = dm_req & ~dm_ack;
    assign fetch_first = if_cand & (starve_cnt == STARVE_TOP);
    assign stall       = (if_req & ~if_ack) | (dm_req & ~dm_ack);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, grant and capture decisions
    always_comb begin
        state_next = state;
        grant_dm   = 1'b0;
        grant_if   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (dm_cand && !fetch_first) begin
                    grant_dm   = 1'b1;
                    state_next = ISSUE;
                end else if (if_cand) begin
                    grant_if   = 1'b1;
                    state_next = ISSUE;
                end else begin
                    state_next = IDLE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (lat_cnt == 3'd0) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = WAIT;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory strobe, latched request and latency counter
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            owner_dm  <= 1'b0;
            owner_we  <= 1'b0;
            lat_cnt   <= 3'd0;
        end else begin
            mem_en <= grant_dm | grant_if;
            mem_we <= grant_dm & dm_we;
            if (grant_dm) begin
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                owner_dm  <= 1'b1;
                owner_we  <= dm_we;
            end else if (grant_if) begin
                mem_addr  <= if_addr;
                mem_wdata <= 32'h0;
                owner_dm  <= 1'b0;
                owner_we  <= 1'b0;
            end else begin
                mem_addr  <= mem_addr;
                mem_wdata <= mem_wdata;
            end
            // WAIT spans MEM_LAT cycles so the capture lines up with read data
            if (state == ISSUE) begin
                lat_cnt <= 3'(MEM_LAT - 1);
            end else if (state == WAIT && lat_cnt != 3'd0) begin
                lat_cnt <= lat_cnt - 3'd1;
            end else begin
                lat_cnt <= lat_cnt;
            end
        end
    end

    // Read-data capture, ack pulses and fetch starvation counter
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rdata   <= 32'h0;
            dm_rdata   <= 32'h0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if_ack <= capture & ~owner_dm;
            dm_ack <= capture & owner_dm;
            if (capture && !owner_dm) begin
                if_rdata <= mem_rdata;
            end else if (capture && !owner_we) begin
                dm_rdata <= mem_rdata;
            end else begin
                if_rdata <= if_rdata;
                dm_rdata <= dm_rdata;
            end
            if (!if_req || grant_if) begin
                starve_cnt <= '0;
            end else if (grant_dm && starve_cnt != STARVE_TOP) begin
                starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= starve_cnt;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=2) with a small
// read-latency memory model; cycle 0 is the cycle a request is first raised.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, dm_ack, mem_en, mem_we, stall;
    logic [31:0] pipe0, pipe1;
    int          tests_run = 0;
    int          tests_failed = 0;

    mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(2)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h10:  return 32'hDEADBEEF;
            32'h40:  return 32'hCAFE0040;
            default: return a ^ 32'h5A5A5A5A;
        endcase
    endfunction

    // Two-stage read pipeline: data valid two cycles after mem_en
    always @(posedge clk) begin
        pipe0 <= (mem_en && !mem_we) ? mem_word(mem_addr) : 32'h0;
        pipe1 <= pipe0;
    end
    assign mem_rdata = pipe1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
        tick(); tick();
        tests_run++;
        if ({mem_en, mem_we, if_ack, dm_ack, mem_addr, mem_wdata, if_rdata, dm_rdata} !== 132'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got en=%b we=%b ia=%b da=%b addr=%h wd=%h ir=%h dr=%h required all 0",
                     mem_en, mem_we, if_ack, dm_ack, mem_addr, mem_wdata, if_rdata, dm_rdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin tests_failed++; $display("FAIL stall_c0: got %b required 1", stall); end
        tick();
        tests_run++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin
            tests_failed++;
            $display("FAIL fetch_issue: got en=%b we=%b addr=%h required en=1 we=0 addr=10", mem_en, mem_we, mem_addr);
        end
        tick();
        tests_run++;
        if (mem_en !== 1'b0 || if_ack !== 1'b0 || stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL fetch_c2: got en=%b ack=%b stall=%b required 0 0 1", mem_en, if_ack, stall);
        end
        tick();
        tests_run++;
        if (if_ack !== 1'b0) begin tests_failed++; $display("FAIL fetch_early_ack: got %b required 0", if_ack); end
        tick();
        tests_run++;
        if (if_ack !== 1'b1 || if_rdata !== 32'hDEADBEEF || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_ack_c4: got ack=%b rdata=%h stall=%b required 1 deadbeef 0", if_ack, if_rdata, stall);
        end
        if_req = 1'b0;
        tick();
        tests_run++;
        if (if_ack !== 1'b0 || stall !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL fetch_after: got ack=%b stall=%b rdata=%h required 0 0 deadbeef", if_ack, stall, if_rdata);
        end
    endtask

    task automatic test_dual();
        int en_c[2];
        int n_en = 0;
        int dack_c = -1;
        int iack_c = -1;
        logic [31:0] dr = 32'h0;
        logic [31:0] ir = 32'h0;
        logic [31:0] en_a[2];
        en_c[0] = -1; en_c[1] = -1; en_a[0] = 32'h0; en_a[1] = 32'h0;
        if_req = 1'b1; if_addr = 32'h20;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (mem_en) begin
                if (n_en < 2) begin en_c[n_en] = c; en_a[n_en] = mem_addr; end
                n_en++;
            end
            if (dm_ack) begin dack_c = c; dr = dm_rdata; dm_req = 1'b0; end
            if (if_ack) begin iack_c = c; ir = if_rdata; if_req = 1'b0; end
        end
        tests_run++;
        if (dack_c !== 4 || dr !== 32'hCAFE0040) begin
            tests_failed++;
            $display("FAIL dual_data_first: got ack_cycle=%0d rdata=%h required 4 cafe0040", dack_c, dr);
        end
        tests_run++;
        if (n_en !== 2 || en_c[0] !== 1 || en_a[0] !== 32'h40 || en_c[1] !== 6 || en_a[1] !== 32'h20) begin
            tests_failed++;
            $display("FAIL dual_issue: got n=%0d c0=%0d a0=%h c1=%0d a1=%h required 2 1 40 6 20",
                     n_en, en_c[0], en_a[0], en_c[1], en_a[1]);
        end
        tests_run++;
        if (iack_c !== 9 || ir !== 32'h5A5A5A7A || dm_rdata !== 32'hCAFE0040) begin
            tests_failed++;
            $display("FAIL dual_fetch_ack: got cycle=%0d if_rdata=%h dm_rdata=%h required 9 5a5a5a7a cafe0040",
                     iack_c, ir, dm_rdata);
        end
    endtask

    task automatic test_store();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h12345678;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin tests_failed++; $display("FAIL store_stall: got %b required 1", stall); end
        tick();
        tests_run++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h80, 32'h12345678}) begin
            tests_failed++;
            $display("FAIL store_issue: got en=%b we=%b addr=%h wd=%h required 1 1 80 12345678",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick();
        tests_run++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_one_cycle: got en=%b we=%b required 0 0", mem_en, mem_we);
        end
        tick(); tick();
        tests_run++;
        if (dm_ack !== 1'b1 || dm_rdata !== 32'hCAFE0040 || if_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_ack: got ack=%b rdata=%h if_ack=%b required 1 cafe0040 0", dm_ack, dm_rdata, if_ack);
        end
        dm_req = 1'b0; dm_we = 1'b0;
        tick();
        tests_run++;
        if (dm_ack !== 1'b0 || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_after: got ack=%b stall=%b required 0 0", dm_ack, stall);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got_a[4];
        logic        got_w[4];
        logic [31:0] exp_a[4];
        logic        exp_w[4];
        int n = 0;
        int fetch_acks = 0;
        exp_a[0] = 32'h100; exp_a[1] = 32'h100; exp_a[2] = 32'h30; exp_a[3] = 32'h100;
        exp_w[0] = 1'b1; exp_w[1] = 1'b1; exp_w[2] = 1'b0; exp_w[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin got_a[i] = 32'h0; got_w[i] = 1'b0; end
        if_req = 1'b1; if_addr = 32'h30;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'h0BAD0BAD;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (mem_en) begin
                if (n < 4) begin got_a[n] = mem_addr; got_w[n] = mem_we; end
                n++;
            end
            if (if_ack) begin fetch_acks++; if_req = 1'b0; end
            if (dm_ack && n >= 4) begin dm_req = 1'b0; dm_we = 1'b0; end
        end
        tests_run++;
        if (n !== 4 || fetch_acks !== 1) begin
            tests_failed++;
            $display("FAIL b2b_count: got grants=%0d fetch_acks=%0d required 4 1", n, fetch_acks);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (got_a[i] !== exp_a[i] || got_w[i] !== exp_w[i]) begin
                tests_failed++;
                $display("FAIL b2b_grant%0d: got addr=%h we=%b required addr=%h we=%b",
                         i, got_a[i], got_w[i], exp_a[i], exp_w[i]);
            end
        end
        tests_run++;
        if (if_rdata !== 32'h5A5A5A6A || dm_rdata !== 32'hCAFE0040) begin
            tests_failed++;
            $display("FAIL b2b_hold: got if_rdata=%h dm_rdata=%h required 5a5a5a6a cafe0040", if_rdata, dm_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int en_c = -1;
        int ack_c = -1;
        int acks = 0;
        logic [31:0] ea = 32'h0;
        logic [31:0] ir = 32'h0;
        if_req = 1'b1; if_addr = 32'h10;
        tick(); tick();
        reset = 1'b1;
        tick();
        tests_run++;
        if ({mem_en, mem_we, if_ack, dm_ack, mem_addr, mem_wdata, if_rdata, dm_rdata} !== 132'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got en=%b ack=%b addr=%h ir=%h dr=%h required all 0",
                     mem_en, if_ack, mem_addr, if_rdata, dm_rdata);
        end
        tick();
        tests_run++;
        if (mem_en !== 1'b0 || if_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ignores_req: got en=%b ack=%b required 0 0", mem_en, if_ack);
        end
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (mem_en && en_c < 0) begin en_c = k; ea = mem_addr; end
            if (if_ack) begin acks++; if (ack_c < 0) begin ack_c = k; ir = if_rdata; end if_req = 1'b0; end
        end
        tests_run++;
        if (en_c !== 1 || ea !== 32'h10) begin
            tests_failed++;
            $display("FAIL reset_rearb_issue: got cycle=%0d addr=%h required 1 10", en_c, ea);
        end
        tests_run++;
        if (ack_c !== 4 || acks !== 1 || ir !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL reset_rearb_ack: got cycle=%0d acks=%0d rdata=%h required 4 1 deadbeef", ack_c, acks, ir);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        tick();
        test_dual();
        tick();
        test_store();
        tick();
        test_back_to_back();
        tick();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
